d_hazard_scoreboard: RTL

//  Decode-stage hazard unit for the 5-stage MIPS pipeline, successor to the fixed Tuse/Tnew decoder.

---
 rtl/d_pkg.sv | 109 ++++++++++
 rtl/d_instr_decode.sv | 126 ++++++++++++
 rtl/d_hazard_scoreboard.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/d_pkg.sv
// Shared opcode/funct encodings, Tnew/Tuse constants and scoreboard types for d_hazard_scoreboard.
package d_pkg;

    localparam int TNEW_W = 2;
    localparam int TUSE_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_SLLV    = 6'h04;
    localparam logic [5:0] F_SRLV    = 6'h06;
    localparam logic [5:0] F_SRAV    = 6'h07;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0c;
    localparam logic [5:0] F_MFHI    = 6'h10;
    localparam logic [5:0] F_MTHI    = 6'h11;
    localparam logic [5:0] F_MFLO    = 6'h12;
    localparam logic [5:0] F_MTLO    = 6'h13;
    localparam logic [5:0] F_MULT    = 6'h18;
    localparam logic [5:0] F_MULTU   = 6'h19;
    localparam logic [5:0] F_DIV     = 6'h1a;
    localparam logic [5:0] F_DIVU    = 6'h1b;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2a;
    localparam logic [5:0] F_SLTU    = 6'h2b;
    localparam logic [5:0] F_ERET    = 6'h18;

    localparam logic [4:0] CP0_MF  = 5'd0;
    localparam logic [4:0] CP0_MT  = 5'd4;
    localparam logic [4:0] CP0_CO  = 5'd16;
    localparam logic [4:0] CP0_EPC = 5'd14;
    localparam logic [4:0] REG_RA  = 5'd31;

    localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_MD   = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;
    localparam logic [TNEW_W-1:0] TNEW_CP0  = 2'd2;
    localparam logic [TNEW_W-1:0] TNEW_JAL  = 2'd0;

    localparam logic [TUSE_W-1:0] TUSE_BR   = 3'd0;
    localparam logic [TUSE_W-1:0] TUSE_ALU  = 3'd1;
    localparam logic [TUSE_W-1:0] TUSE_ST   = 3'd2;
    localparam logic [TUSE_W-1:0] TUSE_NONE = 3'd7;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_start_e;

    typedef struct packed {
        logic              valid;
        logic [4:0]        waddr;
        logic [TNEW_W-1:0] tnew;
        logic              epc_wr;
    } entry_t;

    typedef struct packed {
        logic [4:0]        waddr;
        logic [TNEW_W-1:0] tnew;
        logic [TUSE_W-1:0] tuse_rs;
        logic [TUSE_W-1:0] tuse_rt;
        logic              md_class;
        md_start_e         md_start;
        logic              eret;
        logic              syscall;
        logic              ri;
        logic              epc_wr;
    } dec_t;

    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        if (t != {TNEW_W{1'b0}}) begin
            return t - TNEW_W'(1);
        end else begin
            return {TNEW_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/d_instr_decode.sv
// Combinational D-stage decoder: write address, Tnew, per-operand Tuse and mult/div/CP0 class.
// CP0 instructions (mfc0/mtc0/eret/syscall) and reserved-instruction flagging need CP0_EXC_EN.
module d_instr_decode
    import d_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic       unused_shamt_s;

    assign op_s           = instr[31:26];
    assign rs_s           = instr[25:21];
    assign rt_s           = instr[20:16];
    assign rd_s           = instr[15:11];
    assign funct_s        = instr[5:0];
    assign unused_shamt_s = ^instr[10:6];

    // Instruction class to writer/reader timing
    always_comb begin
        dec          = '0;
        dec.tuse_rs  = TUSE_NONE;
        dec.tuse_rt  = TUSE_NONE;
        dec.md_start = MD_NONE;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV: begin
                        dec.waddr   = rd_s;
                        dec.tnew    = TNEW_ALU;
                        dec.tuse_rs = TUSE_ALU;
                        dec.tuse_rt = TUSE_ALU;
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        dec.waddr   = rd_s;
                        dec.tnew    = TNEW_ALU;
                        dec.tuse_rt = TUSE_ALU;
                    end
                    F_JR: dec.tuse_rs = TUSE_BR;
                    F_MFHI, F_MFLO: begin
                        dec.waddr    = rd_s;
                        dec.tnew     = TNEW_MD;
                        dec.md_class = 1'b1;
                    end
                    F_MTHI, F_MTLO: begin
                        dec.tuse_rs  = TUSE_ALU;
                        dec.md_class = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        dec.tuse_rs  = TUSE_ALU;
                        dec.tuse_rt  = TUSE_ALU;
                        dec.md_class = 1'b1;
                        dec.md_start = (funct_s == F_DIV || funct_s == F_DIVU) ? MD_DIV : MD_MUL;
                    end
                    F_SYSCALL: begin
`ifdef CP0_EXC_EN
                        dec.syscall = 1'b1;
`else
                        dec.syscall = 1'b0;
`endif
                    end
                    default: dec.ri = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.waddr   = rt_s;
                dec.tnew    = TNEW_ALU;
                dec.tuse_rs = TUSE_ALU;
            end
            OP_LUI: begin
                dec.waddr = rt_s;
                dec.tnew  = TNEW_ALU;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.waddr   = rt_s;
                dec.tnew    = TNEW_LOAD;
                dec.tuse_rs = TUSE_ALU;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.tuse_rs = TUSE_ALU;
                dec.tuse_rt = TUSE_ST;
            end
            OP_BEQ, OP_BNE: begin
                dec.tuse_rs = TUSE_BR;
                dec.tuse_rt = TUSE_BR;
            end
            OP_J: dec.ri = 1'b0;
            OP_JAL: begin
                dec.waddr = REG_RA;
                dec.tnew  = TNEW_JAL;
            end
            OP_COP0: begin
`ifdef CP0_EXC_EN
                case (rs_s)
                    CP0_MF: begin
                        dec.waddr = rt_s;
                        dec.tnew  = TNEW_CP0;
                    end
                    CP0_MT: begin
                        dec.tuse_rt = TUSE_ST;
                        dec.epc_wr  = (rd_s == CP0_EPC);
                    end
                    CP0_CO: begin
                        dec.eret = (funct_s == F_ERET);
                        dec.ri   = (funct_s != F_ERET);
                    end
                    default: dec.ri = 1'b1;
                endcase
`else
                dec.ri = 1'b0;
`endif
            end
            default: dec.ri = 1'b1;
        endcase
`ifndef CP0_EXC_EN
        dec.ri = 1'b0;
`endif
    end

endmodule

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage hazard unit: in-flight writer scoreboard, HI/LO busy counter, stall and forward selects.
// Build option CP0_EXC_EN adds CP0 decode, exception flags and the eret-after-mtc0-EPC interlock.
module d_hazard_scoreboard
    import d_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic        md_busy,
    output logic        exc_ri,
    output logic        exc_sys,
    output logic        eret_d
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    dec_t                  dec_s;
    entry_t                sb_r [NUM_STAGES];
    entry_t                e0_next_s;
    md_start_e             e0_md_r;
    md_start_e             e0_md_next_s;
    logic [CNT_W-1:0]      md_cnt_r;
    logic [4:0]            rs_s;
    logic [4:0]            rt_s;
    logic [NUM_STAGES-1:0] rs_hz_s, rt_hz_s, rs_fw_s, rt_fw_s, epc_pend_s;
    logic                  md_hz_s;
    logic                  eret_hz_s;

    assign rs_s = instr_d[25:21];
    assign rt_s = instr_d[20:16];

    d_instr_decode u_dec (
        .instr (instr_d),
        .dec   (dec_s)
    );

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_cmp
        assign rs_hz_s[k]    = sb_r[k].valid && (sb_r[k].waddr == rs_s) && (sb_r[k].waddr != 5'd0)
                               && ({1'b0, sb_r[k].tnew} > dec_s.tuse_rs);
        assign rt_hz_s[k]    = sb_r[k].valid && (sb_r[k].waddr == rt_s) && (sb_r[k].waddr != 5'd0)
                               && ({1'b0, sb_r[k].tnew} > dec_s.tuse_rt);
        assign rs_fw_s[k]    = sb_r[k].valid && (sb_r[k].waddr == rs_s) && (rs_s != 5'd0)
                               && (sb_r[k].tnew == {TNEW_W{1'b0}});
        assign rt_fw_s[k]    = sb_r[k].valid && (sb_r[k].waddr == rt_s) && (rt_s != 5'd0)
                               && (sb_r[k].tnew == {TNEW_W{1'b0}});
        assign epc_pend_s[k] = sb_r[k].valid && sb_r[k].epc_wr;
    end

    // Youngest (lowest index) ready producer wins; select is 1 + entry index
    function automatic logic [1:0] fwd_pick(input logic [NUM_STAGES-1:0] m);
        logic [1:0] sel;
        sel = 2'd0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (m[k]) begin
                sel = 2'(k + 1);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign md_hz_s   = dec_s.md_class && ((md_cnt_r != {CNT_W{1'b0}}) || (e0_md_r != MD_NONE));
    assign eret_hz_s = dec_s.eret && (|epc_pend_s);
    assign md_busy   = (md_cnt_r != {CNT_W{1'b0}});
    assign exc_ri    = valid_d && dec_s.ri;
    assign exc_sys   = valid_d && dec_s.syscall;
    assign eret_d    = valid_d && dec_s.eret;

    // Stall and forward selects for the instruction currently in D
    always_comb begin
        stall      = 1'b0;
        fwd_rs_sel = 2'd0;
        fwd_rt_sel = 2'd0;
        if (valid_d) begin
            stall      = (|rs_hz_s) || (|rt_hz_s) || md_hz_s || eret_hz_s;
            fwd_rs_sel = fwd_pick(rs_fw_s);
            fwd_rt_sel = fwd_pick(rt_fw_s);
        end else begin
            stall      = 1'b0;
            fwd_rs_sel = 2'd0;
            fwd_rt_sel = 2'd0;
        end
    end

    // Next E-stage entry: flush beats stall, a stalled or absent instruction becomes a bubble
    always_comb begin
        e0_next_s    = '0;
        e0_md_next_s = MD_NONE;
        if (!flush && valid_d && !stall) begin
            e0_next_s.valid  = 1'b1;
            e0_next_s.waddr  = dec_s.waddr;
            e0_next_s.tnew   = dec_s.tnew;
            e0_next_s.epc_wr = dec_s.epc_wr;
            e0_md_next_s     = dec_s.md_start;
        end else begin
            e0_next_s    = '0;
            e0_md_next_s = MD_NONE;
        end
    end

    // Scoreboard shift with saturating Tnew countdown
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                sb_r[k] <= '0;
            end
            e0_md_r <= MD_NONE;
        end else begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                sb_r[k].valid  <= sb_r[k-1].valid && !flush;
                sb_r[k].waddr  <= sb_r[k-1].waddr;
                sb_r[k].tnew   <= tnew_dec(sb_r[k-1].tnew);
                sb_r[k].epc_wr <= sb_r[k-1].epc_wr;
            end
            sb_r[0] <= e0_next_s;
            e0_md_r <= e0_md_next_s;
        end
    end

    // HI/LO busy counter, armed as a mult/div leaves E
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r <= {CNT_W{1'b0}};
        end else if (e0_md_r == MD_MUL) begin
            md_cnt_r <= CNT_W'(MUL_CYCLES);
        end else if (e0_md_r == MD_DIV) begin
            md_cnt_r <= CNT_W'(DIV_CYCLES);
        end else if (md_cnt_r != {CNT_W{1'b0}}) begin
            md_cnt_r <= md_cnt_r - CNT_W'(1);
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

endmodule
